// File: rtl/hazard_sb_pkg.sv
// Shared types and constants for the hazard unit.
//   FWD_*        : E-stage forwarding mux selects
//   div_state_t  : divider occupancy FSM states
//   stall_ctl_t  : per-stage hold enables F..W
//   flush_ctl_t  : per-stage bubble enables D..W
package hazard_sb_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
    logic w;
  } stall_ctl_t;

  typedef struct packed {
    logic d;
    logic e;
    logic m;
    logic w;
  } flush_ctl_t;

endpackage

// File: rtl/hazard_sb_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : pipeline side, drives stage register indices/controls, receives
//            forwarding selects, stall/flush enables and divider status
//   slave  : hazard unit side
interface hazard_sb_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);

  logic [REG_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic             branchD, jrD;
  logic             regwriteE, memtoregE, divstartE;
  logic             regwriteM, memtoregM, redirectM, exceptM;
  logic             regwriteW;

  logic             forwardaD, forwardbD;
  logic [1:0]       forwardaE, forwardbE;
  logic             stallF, stallD, stallE, stallM, stallW;
  logic             flushD, flushE, flushM, flushW;
  logic             div_busy, div_doneE;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           branchD, jrD, regwriteE, memtoregE, divstartE,
           regwriteM, memtoregM, redirectM, exceptM, regwriteW,
    input  forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW,
           div_busy, div_doneE, stall_cycles
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           branchD, jrD, regwriteE, memtoregE, divstartE,
           regwriteM, memtoregM, redirectM, exceptM, regwriteW,
    output forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW,
           div_busy, div_doneE, stall_cycles
  );

endinterface

// File: rtl/hazard_div_fsm.sv
// Divider occupancy tracker: holds E for DIV_CYCLES+1 cycles after an
// accepted start, then pulses done for the cycle E is allowed to advance.
//   clk, rst : clock, synchronous active-high reset
//   start    : div in E that is on the correct path
//   abort    : exception, return to IDLE next cycle
//   busy     : FSM in BUSY (registered)
//   done     : FSM in DONE (registered)
//   stall    : E must hold this cycle
module hazard_div_fsm
  import hazard_sb_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic stall
);

  localparam int unsigned DCNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] CNT_LOAD = DCNT_W'(DIV_CYCLES - 1);

  div_state_t        state_q, state_d;
  logic [DCNT_W-1:0] cnt_q, cnt_d;
  logic              busy_q, done_q;
  logic              accept_c;

  // Only IDLE accepts a start; a start seen in DONE is the same div leaving E.
  assign accept_c = (state_q == IDLE) && start && !abort;

  // Next-state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
        BUSY: begin
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - DCNT_W'(1);
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == BUSY);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = accept_c || busy_q;

endmodule

// File: rtl/hazard_sb.sv
// Hazard unit for the 5-stage core: forwarding selects, load-use and
// D-stage branch operand stalls, divider occupancy stall, redirect and
// exception flushes, and a saturating count of D-stall cycles.
//   clk, rst : clock, synchronous active-high reset
//   hz       : slave side of hazard_sb_if (stage indices/controls in,
//              forwarding/stall/flush/divider status/stall count out)
module hazard_sb
  import hazard_sb_pkg::*;
#(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BRANCH_IN_D = 1
) (
  input  logic        clk,
  input  logic        rst,
  hazard_sb_if.slave  hz
);

  stall_ctl_t       stall_c;
  flush_ctl_t       flush_c;
  logic             lwstall_c, brstall_c;
  logic             div_start_c, div_busy, div_done, div_stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Register $0 is hardwired, so it never produces a hazard.
  function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst);
    return (dst != REG_W'(0)) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] wm,
                                       input logic             rwm,
                                       input logic [REG_W-1:0] ww,
                                       input logic             rww);
    if (rwm && reg_hit(src, wm)) return FWD_M;
    if (rww && reg_hit(src, ww)) return FWD_W;
    return FWD_RF;
  endfunction

  // Forwarding
  assign hz.forwardaE = fwd_e(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
  assign hz.forwardbE = fwd_e(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
  assign hz.forwardaD = hz.regwriteM && !hz.memtoregM && reg_hit(hz.rsD, hz.writeregM);
  assign hz.forwardbD = hz.regwriteM && !hz.memtoregM && reg_hit(hz.rtD, hz.writeregM);

  // Load-use and D-stage compare operand hazards
  assign lwstall_c = hz.memtoregE && hz.regwriteE &&
                     (reg_hit(hz.rsD, hz.writeregE) || reg_hit(hz.rtD, hz.writeregE));
  assign brstall_c = (BRANCH_IN_D != 0) && (hz.branchD || hz.jrD) &&
                     ((hz.regwriteE && (reg_hit(hz.rsD, hz.writeregE) ||
                                        reg_hit(hz.rtD, hz.writeregE))) ||
                      (hz.memtoregM && (reg_hit(hz.rsD, hz.writeregM) ||
                                        reg_hit(hz.rtD, hz.writeregM))));

  // A div behind a redirect is wrong-path and must not occupy the divider.
  assign div_start_c = hz.divstartE && !hz.redirectM;

  hazard_div_fsm #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_fsm (
    .clk   (clk),
    .rst   (rst),
    .start (div_start_c),
    .abort (hz.exceptM),
    .busy  (div_busy),
    .done  (div_done),
    .stall (div_stall)
  );

  // Stall/flush priority: reset, exception, redirect, divider, load/branch
  always_comb begin
    stall_c = '0;
    flush_c = '0;
    if (rst) begin
      flush_c = '1;
    end else if (hz.exceptM) begin
      flush_c.d = 1'b1;
      flush_c.e = 1'b1;
      flush_c.m = 1'b1;
    end else if (hz.redirectM) begin
      flush_c.d = 1'b1;
      flush_c.e = 1'b1;
    end else if (div_stall) begin
      stall_c.f = 1'b1;
      stall_c.d = 1'b1;
      stall_c.e = 1'b1;
      flush_c.m = 1'b1;
    end else if (lwstall_c || brstall_c) begin
      stall_c.f = 1'b1;
      stall_c.d = 1'b1;
      flush_c.e = 1'b1;
    end
  end

  assign hz.stallF = stall_c.f;
  assign hz.stallD = stall_c.d;
  assign hz.stallE = stall_c.e;
  assign hz.stallM = stall_c.m;
  assign hz.stallW = stall_c.w;
  assign hz.flushD = flush_c.d;
  assign hz.flushE = flush_c.e;
  assign hz.flushM = flush_c.m;
  assign hz.flushW = flush_c.w;

  assign hz.div_busy  = div_busy && !rst;
  assign hz.div_doneE = div_done && !rst;

  // Saturating D-stall cycle counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c.d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the hazard rules.
module tb_hazard_sb;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned DIV_CYCLES = 4;
  localparam int unsigned CNT_W      = 2;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_sb_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

  hazard_sb #(
    .REG_W       (REG_W),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W),
    .BRANCH_IN_D (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  task automatic idle_in();
    hz.rsD = '0; hz.rtD = '0; hz.rsE = '0; hz.rtE = '0;
    hz.writeregE = '0; hz.writeregM = '0; hz.writeregW = '0;
    hz.branchD = 0; hz.jrD = 0; hz.regwriteE = 0; hz.memtoregE = 0; hz.divstartE = 0;
    hz.regwriteM = 0; hz.memtoregM = 0; hz.redirectM = 0; hz.exceptM = 0; hz.regwriteW = 0;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at +4.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    hz.memtoregE = 1; hz.regwriteE = 1; hz.writeregE = 5'd5; hz.rsD = 5'd5;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_in();
    set_load_use();
    hz.divstartE = 1;
    next_cycle();
    next_cycle();
    #3;
    checks++;
    if ({hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW} !== 5'b0) begin
      errors++; $display("FAIL reset_stalls got %b want 00000",
                         {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW});
    end
    checks++;
    if ({hz.flushD, hz.flushE, hz.flushM, hz.flushW} !== 4'b1111) begin
      errors++; $display("FAIL reset_flushes got %b want 1111",
                         {hz.flushD, hz.flushE, hz.flushM, hz.flushW});
    end
    checks++;
    if ({hz.div_busy, hz.div_doneE} !== 2'b00) begin
      errors++; $display("FAIL reset_div got %b want 00", {hz.div_busy, hz.div_doneE});
    end
    checks++;
    if (hz.stall_cycles !== 2'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", hz.stall_cycles);
    end
    next_cycle();
    rst = 0;
    idle_in();
  endtask

  task automatic test_forward();
    next_cycle();
    hz.rsE = 5'd3; hz.rtE = 5'd3; hz.writeregM = 5'd3; hz.regwriteM = 1;
    hz.writeregW = 5'd3; hz.regwriteW = 1;
    #3;
    checks++;
    if (hz.forwardaE !== 2'b10) begin
      errors++; $display("FAIL fwdE_M got %b want 10", hz.forwardaE);
    end
    hz.regwriteM = 0;
    #1;
    checks++;
    if ({hz.forwardaE, hz.forwardbE} !== 4'b0101) begin
      errors++; $display("FAIL fwdE_W got %b want 0101", {hz.forwardaE, hz.forwardbE});
    end
    hz.rsE = 5'd0; hz.writeregW = 5'd0; hz.writeregM = 5'd0; hz.regwriteM = 1;
    #1;
    checks++;
    if (hz.forwardaE !== 2'b00) begin
      errors++; $display("FAIL fwdE_zero got %b want 00", hz.forwardaE);
    end
    hz.writeregM = 5'd4; hz.rsD = 5'd4; hz.rtD = 5'd9; hz.memtoregM = 0;
    #1;
    checks++;
    if ({hz.forwardaD, hz.forwardbD} !== 2'b10) begin
      errors++; $display("FAIL fwdD_alu got %b want 10", {hz.forwardaD, hz.forwardbD});
    end
    hz.memtoregM = 1;
    #1;
    checks++;
    if ({hz.forwardaD, hz.forwardbD} !== 2'b00) begin
      errors++; $display("FAIL fwdD_load got %b want 00", {hz.forwardaD, hz.forwardbD});
    end
    idle_in();
  endtask

  task automatic test_load_use();
    next_cycle();
    set_load_use();
    #3;
    checks++;
    if ({hz.stallF, hz.stallD, hz.stallE, hz.flushE} !== 4'b1101) begin
      errors++; $display("FAIL lwstall got %b want 1101",
                         {hz.stallF, hz.stallD, hz.stallE, hz.flushE});
    end
    next_cycle();
    idle_in();
    #3;
    checks++;
    if ({hz.stallF, hz.stallD, hz.flushE, hz.stall_cycles} !== {3'b000, 2'd1}) begin
      errors++; $display("FAIL lwstall_after got %b want 00001",
                         {hz.stallF, hz.stallD, hz.flushE, hz.stall_cycles});
    end
  endtask

  task automatic test_div();
    logic s, b, d;
    next_cycle();
    idle_in();
    hz.divstartE = 1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cycle();
      if (i == 6) hz.divstartE = 0;
      #3;
      s = (i < 5);
      b = (i >= 1 && i <= 4);
      d = (i == 5);
      checks++;
      if ({hz.stallF, hz.stallD, hz.stallE, hz.flushM, hz.flushE} !== {s, s, s, s, 1'b0}) begin
        errors++; $display("FAIL div_stall cyc %0d got %b want %b", i,
                           {hz.stallF, hz.stallD, hz.stallE, hz.flushM, hz.flushE},
                           {s, s, s, s, 1'b0});
      end
      checks++;
      if ({hz.div_busy, hz.div_doneE} !== {b, d}) begin
        errors++; $display("FAIL div_status cyc %0d got %b want %b", i,
                           {hz.div_busy, hz.div_doneE}, {b, d});
      end
    end
    checks++;
    if (hz.stall_cycles !== 2'd3) begin
      errors++; $display("FAIL div_count got %0d want 3", hz.stall_cycles);
    end
  endtask

  task automatic test_div_except();
    next_cycle();
    hz.divstartE = 1;
    next_cycle();
    next_cycle();
    hz.exceptM = 1;
    #3;
    checks++;
    if ({hz.flushD, hz.flushE, hz.flushM, hz.stallF, hz.stallD, hz.stallE} !== 6'b111000) begin
      errors++; $display("FAIL except_busy got %b want 111000",
                         {hz.flushD, hz.flushE, hz.flushM, hz.stallF, hz.stallD, hz.stallE});
    end
    next_cycle();
    idle_in();
    #3;
    checks++;
    if ({hz.div_busy, hz.stallE, hz.flushM} !== 3'b000) begin
      errors++; $display("FAIL except_after got %b want 000",
                         {hz.div_busy, hz.stallE, hz.flushM});
    end
  endtask

  task automatic test_redirect_branch();
    next_cycle();
    hz.redirectM = 1; hz.divstartE = 1;
    #3;
    checks++;
    if ({hz.flushD, hz.flushE, hz.flushM, hz.stallD, hz.stallE} !== 5'b11000) begin
      errors++; $display("FAIL redirect got %b want 11000",
                         {hz.flushD, hz.flushE, hz.flushM, hz.stallD, hz.stallE});
    end
    next_cycle();
    idle_in();
    #3;
    checks++;
    if ({hz.div_busy, hz.stallE} !== 2'b00) begin
      errors++; $display("FAIL redirect_nodiv got %b want 00", {hz.div_busy, hz.stallE});
    end
    hz.branchD = 1; hz.rsD = 5'd7; hz.regwriteE = 1; hz.writeregE = 5'd7;
    #1;
    checks++;
    if ({hz.stallF, hz.stallD, hz.flushE} !== 3'b111) begin
      errors++; $display("FAIL brstall_E got %b want 111", {hz.stallF, hz.stallD, hz.flushE});
    end
    hz.regwriteE = 0; hz.memtoregM = 1; hz.writeregM = 5'd7;
    #1;
    checks++;
    if (hz.stallD !== 1'b1) begin
      errors++; $display("FAIL brstall_M got %b want 1", hz.stallD);
    end
    hz.branchD = 0;
    #1;
    checks++;
    if (hz.stallD !== 1'b0) begin
      errors++; $display("FAIL nobranch got %b want 0", hz.stallD);
    end
    idle_in();
  endtask

  task automatic test_saturate();
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0;
    set_load_use();
    for (int i = 0; i < 5; i++) begin
      #3;
      checks++;
      if (int'(hz.stall_cycles) != ((i < CNT_MAX) ? i : CNT_MAX)) begin
        errors++; $display("FAIL sat_count cyc %0d got %0d want %0d", i, hz.stall_cycles,
                           (i < CNT_MAX) ? i : CNT_MAX);
      end
      next_cycle();
    end
    #3;
    checks++;
    if (hz.stall_cycles !== 2'd3) begin
      errors++; $display("FAIL sat_hold got %0d want 3", hz.stall_cycles);
    end
    rst = 1;
    next_cycle();
    #3;
    checks++;
    if ({hz.stall_cycles, hz.stallD, hz.flushD, hz.flushE, hz.flushM, hz.flushW} !== 7'b0001111) begin
      errors++; $display("FAIL sat_reset got %b want 0001111",
                         {hz.stall_cycles, hz.stallD, hz.flushD, hz.flushE, hz.flushM, hz.flushW});
    end
    next_cycle();
    rst = 0;
    idle_in();
  endtask

  // Reference: E forward source priority M over W, register 0 never forwarded.
  function automatic logic [1:0] model_fwd_e(int src, int wm, bit rwm, int ww, bit rww);
    if (src != 0 && src == wm && rwm) return 2'b10;
    if (src != 0 && src == ww && rww) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_random();
    int  busy_left = 0;
    bit  done_pend = 0;
    int  cnt = 0;
    int  rsd, rtd, rse, rte, we, wm, ww;
    bit  lw, br, accept, dstall;
    logic [14:0] exp_v, got_v;
    logic [4:0]  st;
    logic [3:0]  fl;
    for (int n = 0; n < 600; n++) begin
      next_cycle();
      rsd = $urandom_range(0, 3); rtd = $urandom_range(0, 3);
      rse = $urandom_range(0, 3); rte = $urandom_range(0, 3);
      we  = $urandom_range(0, 3); wm  = $urandom_range(0, 3); ww = $urandom_range(0, 3);
      hz.rsD = 5'(rsd); hz.rtD = 5'(rtd); hz.rsE = 5'(rse); hz.rtE = 5'(rte);
      hz.writeregE = 5'(we); hz.writeregM = 5'(wm); hz.writeregW = 5'(ww);
      hz.branchD   = ($urandom_range(0, 3) == 0);
      hz.jrD       = ($urandom_range(0, 7) == 0);
      hz.regwriteE = 1'($urandom);
      hz.memtoregE = ($urandom_range(0, 3) == 0);
      hz.divstartE = ($urandom_range(0, 2) == 0);
      hz.regwriteM = 1'($urandom);
      hz.memtoregM = ($urandom_range(0, 3) == 0);
      hz.redirectM = ($urandom_range(0, 7) == 0);
      hz.exceptM   = ($urandom_range(0, 15) == 0);
      hz.regwriteW = 1'($urandom);
      #3;
      lw = hz.memtoregE && hz.regwriteE && we != 0 && (we == rsd || we == rtd);
      br = (hz.branchD || hz.jrD) &&
           ((hz.regwriteE && we != 0 && (we == rsd || we == rtd)) ||
            (hz.memtoregM && wm != 0 && (wm == rsd || wm == rtd)));
      accept = busy_left == 0 && !done_pend && hz.divstartE && !hz.redirectM && !hz.exceptM;
      dstall = accept || busy_left > 0;
      st = 5'b0; fl = 4'b0;
      if (hz.exceptM)        fl = 4'b1110;
      else if (hz.redirectM) fl = 4'b1100;
      else if (dstall)       begin st = 5'b11100; fl = 4'b0010; end
      else if (lw || br)     begin st = 5'b11000; fl = 4'b0100; end
      exp_v = {wm != 0 && wm == rsd && hz.regwriteM && !hz.memtoregM,
               wm != 0 && wm == rtd && hz.regwriteM && !hz.memtoregM,
               model_fwd_e(rse, wm, hz.regwriteM, ww, hz.regwriteW),
               model_fwd_e(rte, wm, hz.regwriteM, ww, hz.regwriteW),
               st, fl, busy_left > 0, done_pend};
      got_v = {hz.forwardaD, hz.forwardbD, hz.forwardaE, hz.forwardbE,
               hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW,
               hz.flushD, hz.flushE, hz.flushM, hz.flushW, hz.div_busy, hz.div_doneE};
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL rand_outputs iter %0d got %b want %b", n, got_v, exp_v);
      end
      checks++;
      if (int'(hz.stall_cycles) != cnt) begin
        errors++; $display("FAIL rand_count iter %0d got %0d want %0d", n, hz.stall_cycles, cnt);
      end
      // Advance the model across the coming edge
      if (st[3] && cnt < CNT_MAX) cnt++;
      if (hz.exceptM) begin
        busy_left = 0; done_pend = 0;
      end else if (accept) begin
        busy_left = DIV_CYCLES; done_pend = 0;
      end else if (busy_left > 0) begin
        busy_left--; done_pend = (busy_left == 0);
      end else begin
        done_pend = 0;
      end
    end
    idle_in();
  endtask

  initial begin
    rst = 1;
    idle_in();
    test_reset();
    test_forward();
    test_load_use();
    test_div();
    test_div_except();
    test_redirect_branch();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
